// File: rtl/mips_regbank_pkg.sv
// Shared widths and types for the MIPS register bank slice.
// Build option: REGBANK_RESET_CLEAR_EN (reset also clears the data array).
package mips_regbank_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regbank_scoreboard.sv
// Per-register pending-write counters, sticky saturation errors and the
// decode stall derived from outstanding writes on either source register.
module regbank_scoreboard
    import mips_regbank_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  reg_addr_t rs_addr,
    input  reg_addr_t rt_addr,
    input  logic      reserve_valid,
    input  reg_addr_t reserve_addr,
    input  logic      wb_valid,
    input  reg_addr_t wb_addr,
    output logic      stall,
    output logic      err_overflow,
    output logic      err_underflow
);

    localparam cnt_t CNT_MAX = '1;

    cnt_t                pend      [NUM_REGS];
    cnt_t                pend_next [NUM_REGS];
    logic [NUM_REGS-1:0] inc_v;
    logic [NUM_REGS-1:0] dec_v;
    logic                ovf_hit;
    logic                unf_hit;
    logic                rs_hz;
    logic                rt_hz;

    // Register 0 never gets an inc/dec, so its counter stays at its reset value of 0.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        if (reserve_valid && reserve_addr != REG_ZERO) inc_v[reserve_addr] = 1'b1;
        if (wb_valid && wb_addr != REG_ZERO)           dec_v[wb_addr]      = 1'b1;
    end

    always_comb begin
        ovf_hit = 1'b0;
        unf_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            pend_next[i] = pend[i];
            if (inc_v[i] && !dec_v[i]) begin
                if (pend[i] == CNT_MAX) ovf_hit = 1'b1;
                else                    pend_next[i] = pend[i] + cnt_t'(1);
            end else if (dec_v[i] && !inc_v[i]) begin
                if (pend[i] == '0) unf_hit = 1'b1;
                else               pend_next[i] = pend[i] - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) pend[i] <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            pend <= pend_next;
            if (ovf_hit) err_overflow  <= 1'b1;
            if (unf_hit) err_underflow <= 1'b1;
        end
    end

    // A last outstanding write landing this cycle is served by the read bypass.
    function automatic logic hazard(input reg_addr_t a, input cnt_t cnt, input logic wb_hit);
        return (a != REG_ZERO) && (cnt != '0) && !(wb_hit && cnt == cnt_t'(1));
    endfunction

    assign rs_hz = hazard(rs_addr, pend[rs_addr], wb_valid && wb_addr == rs_addr);
    assign rt_hz = hazard(rt_addr, pend[rt_addr], wb_valid && wb_addr == rt_addr);
    assign stall = rs_hz | rt_hz;

endmodule

// File: rtl/regbank_writeback.sv
// MIPS register bank: 32-entry data array, two bypassed read ports, pending-write scoreboard.
// Build option: REGBANK_RESET_CLEAR_EN makes reset also clear the data array.
module regbank_writeback
    import mips_regbank_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  reg_addr_t rs_addr,
    input  reg_addr_t rt_addr,
    output reg_data_t rs_data,
    output reg_data_t rt_data,
    input  logic      reserve_valid,
    input  reg_addr_t reserve_addr,
    input  logic      wb_valid,
    input  reg_addr_t wb_addr,
    input  reg_data_t wb_data,
    output logic      stall,
    output logic      err_overflow,
    output logic      err_underflow
);

    reg_data_t regs [NUM_REGS];
    logic      wr_en;

    assign wr_en = wb_valid && (wb_addr != REG_ZERO);

`ifdef REGBANK_RESET_CLEAR_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wb_addr] <= wb_data;
        end
    end
`else
    // Data array is not reset; writes are merely blocked while reset is held.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) regs[wb_addr] <= wb_data;
    end
`endif

    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == REG_ZERO)                   rs_data = '0;
        else if (wb_valid && wb_addr == rs_addr)   rs_data = wb_data;
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == REG_ZERO)                   rt_data = '0;
        else if (wb_valid && wb_addr == rt_addr)   rt_data = wb_data;
    end

    regbank_scoreboard u_scoreboard (
        .clk           (clk),
        .reset_n       (reset_n),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .stall         (stall),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

endmodule

// File: tb/tb_regbank_writeback.sv
// Directed, table-driven bench for regbank_writeback; honours REGBANK_RESET_CLEAR_EN
// when deciding what the data array holds after reset.
module tb_regbank_writeback;
    import mips_regbank_pkg::*;

    logic      clk = 1'b0;
    logic      reset_n;
    reg_addr_t rs_addr, rt_addr, reserve_addr, wb_addr;
    reg_data_t rs_data, rt_data, wb_data;
    logic      reserve_valid, wb_valid;
    logic      stall, err_overflow, err_underflow;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct packed {
        reg_addr_t rs;
        reg_addr_t rt;
        logic      rv;
        reg_addr_t ra;
        logic      wv;
        reg_addr_t wa;
        reg_data_t wd;
        logic      chk_rs;
        reg_data_t ers;
        logic      chk_rt;
        reg_data_t ert;
        logic      est;
        logic      eovf;
        logic      eunf;
    } vec_t;

    vec_t tbl[$];

    regbank_writeback dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .stall         (stall),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want test done");
        $fatal(1);
    end

    function automatic vec_t mk(
        input int rs, input int rt, input logic rv, input int ra,
        input logic wv, input int wa, input reg_data_t wd,
        input logic cr, input reg_data_t ers, input logic ct, input reg_data_t ert,
        input logic st, input logic ov, input logic un);
        vec_t v;
        v.rs = reg_addr_t'(rs);  v.rt = reg_addr_t'(rt);
        v.rv = rv;               v.ra = reg_addr_t'(ra);
        v.wv = wv;               v.wa = reg_addr_t'(wa);  v.wd = wd;
        v.chk_rs = cr;  v.ers = ers;
        v.chk_rt = ct;  v.ert = ert;
        v.est = st;  v.eovf = ov;  v.eunf = un;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rs_addr = v.rs;  rt_addr = v.rt;
        reserve_valid = v.rv;  reserve_addr = v.ra;
        wb_valid = v.wv;  wb_addr = v.wa;  wb_data = v.wd;
    endtask

    // One cycle: drive after the edge, check combinational outputs mid-cycle,
    // the following edge then commits these inputs.
    task automatic run_vec(input vec_t v, input string name);
        @(posedge clk); #1;
        apply(v);
        @(negedge clk);
        if (v.chk_rs) check({name, " rs_data"}, rs_data, v.ers);
        if (v.chk_rt) check({name, " rt_data"}, rt_data, v.ert);
        check({name, " stall"}, {31'b0, stall}, {31'b0, v.est});
        check({name, " err_overflow"}, {31'b0, err_overflow}, {31'b0, v.eovf});
        check({name, " err_underflow"}, {31'b0, err_underflow}, {31'b0, v.eunf});
    endtask

    task automatic do_reset(input vec_t during);
        @(posedge clk); #1;
        reset_n = 1'b0;
        apply(during);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, '0, 0, '0, 0, '0, 0, 0, 0));
    endtask

    localparam logic CLR =
`ifdef REGBANK_RESET_CLEAR_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        reset_n = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, '0, 0, '0, 0, '0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        run_vec(mk(0, 0, 0, 0, 0, 0, '0, 1, '0, 1, '0, 0, 0, 0), "post_reset0");
        run_vec(mk(31, 1, 0, 0, 0, 0, '0, CLR, '0, CLR, '0, 0, 0, 0), "post_reset_regs");

        // Give reg 7 a value, then reset with reserve/write-back driven (must be ignored).
        run_vec(mk(0, 0, 1, 7, 0, 0, '0, 1, '0, 1, '0, 0, 0, 0), "res7");
        run_vec(mk(7, 0, 0, 0, 1, 7, 32'h77, 1, 32'h77, 1, '0, 0, 0, 0), "wb7");
        do_reset(mk(0, 0, 1, 6, 1, 7, 32'h99, 0, '0, 0, '0, 0, 0, 0));
        run_vec(mk(7, 6, 0, 0, 0, 0, '0, 1, CLR ? 32'h0 : 32'h77, CLR, '0, 0, 0, 0), "reset_ignores_inputs");

        tbl.push_back(mk(0, 0, 1, 8, 0, 0, '0,            1, '0,            1, '0,            0, 0, 0));
        tbl.push_back(mk(8, 0, 0, 0, 1, 8, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, '0,            0, 0, 0));
        tbl.push_back(mk(8, 0, 0, 0, 0, 0, '0,            1, 32'hDEADBEEF, 1, '0,            0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h12345678, 1, '0,            1, '0,            0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, '0,            1, '0,            1, '0,            0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 5, 0, 0, '0,            1, '0,            1, '0,            0, 0, 0));
        tbl.push_back(mk(5, 8, 0, 0, 0, 0, '0,            0, '0,            1, 32'hDEADBEEF, 1, 0, 0));
        tbl.push_back(mk(5, 8, 0, 0, 1, 5, 32'hAA,       1, 32'hAA,       1, 32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(mk(5, 5, 0, 0, 0, 0, '0,            1, 32'hAA,       1, 32'hAA,       0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 9, 0, 0, '0,            1, '0,            1, '0,            0, 0, 0));
        tbl.push_back(mk(9, 0, 1, 9, 0, 0, '0,            0, '0,            1, '0,            1, 0, 0));
        tbl.push_back(mk(0, 9, 0, 0, 0, 0, '0,            1, '0,            0, '0,            1, 0, 0));
        tbl.push_back(mk(0, 9, 0, 0, 1, 9, 32'h11,       1, '0,            1, 32'h11,       1, 0, 0));
        tbl.push_back(mk(0, 9, 0, 0, 1, 9, 32'h22,       1, '0,            1, 32'h22,       0, 0, 0));
        tbl.push_back(mk(8, 9, 0, 0, 0, 0, '0,            1, 32'hDEADBEEF, 1, 32'h22,       0, 0, 0));
        tbl.push_back(mk(9, 0, 1, 9, 1, 9, 32'h33,       1, 32'h33,       1, '0,            0, 0, 0));
        tbl.push_back(mk(9, 0, 0, 0, 0, 0, '0,            1, 32'h33,       1, '0,            0, 0, 0));
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Four reservations of reg 3: the fourth saturates at 3 and flags overflow.
        run_vec(mk(0, 0, 1, 3, 0, 0, '0, 1, '0, 1, '0, 0, 0, 0), "ovf_res1");
        run_vec(mk(3, 0, 1, 3, 0, 0, '0, 0, '0, 1, '0, 1, 0, 0), "ovf_res2");
        run_vec(mk(3, 0, 1, 3, 0, 0, '0, 0, '0, 1, '0, 1, 0, 0), "ovf_res3");
        run_vec(mk(3, 0, 1, 3, 0, 0, '0, 0, '0, 1, '0, 1, 0, 0), "ovf_res4");
        run_vec(mk(3, 0, 0, 0, 0, 0, '0, 0, '0, 1, '0, 1, 1, 0), "ovf_flag");
        run_vec(mk(3, 0, 0, 0, 1, 3, 32'h1, 1, 32'h1, 1, '0, 1, 1, 0), "ovf_wb1");
        run_vec(mk(3, 0, 0, 0, 1, 3, 32'h2, 1, 32'h2, 1, '0, 1, 1, 0), "ovf_wb2");
        run_vec(mk(3, 0, 0, 0, 1, 3, 32'h3, 1, 32'h3, 1, '0, 0, 1, 0), "ovf_wb3");
        run_vec(mk(3, 0, 0, 0, 0, 0, '0, 1, 32'h3, 1, '0, 0, 1, 0), "ovf_drained");

        // Write-back with nothing pending: flag underflow, data still lands.
        run_vec(mk(4, 0, 0, 0, 1, 4, 32'h4444, 1, 32'h4444, 1, '0, 0, 1, 0), "unf_wb");
        run_vec(mk(4, 0, 0, 0, 0, 0, '0, 1, 32'h4444, 1, '0, 0, 1, 1), "unf_flag");
        run_vec(mk(0, 4, 0, 0, 0, 0, '0, 1, '0, 1, 32'h4444, 0, 1, 1), "sticky1");
        run_vec(mk(0, 0, 1, 12, 0, 0, '0, 1, '0, 1, '0, 0, 1, 1), "sticky2_res12");

        // Reset mid-operation drops the reservation of 12 and clears both flags.
        do_reset(mk(0, 0, 0, 0, 0, 0, '0, 0, '0, 0, '0, 0, 0, 0));
        run_vec(mk(4, 12, 0, 0, 0, 0, '0, 1, CLR ? 32'h0 : 32'h4444, CLR, '0, 0, 0, 0), "reset_mid_op");
        run_vec(mk(12, 0, 0, 0, 0, 0, '0, CLR, '0, 1, '0, 0, 0, 0), "reset_mid_op2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regbank_writeback.md
Name: regbank_writeback

Overview:
- MIPS register bank. It consumes the destination-register index chosen by the destination mux, which arrives as a reservation at issue, and the write-back data that arrives later.
- Holds 32 general registers, two combinational read ports with write-back bypass, and a per-register pending-write scoreboard.
- Drives a stall signal back to decode when a source register still has an outstanding write.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- CNT_W, 2, width of the per-register pending-write counter (max 2**CNT_W-1 outstanding).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- rs_addr  in  ADDR_W  read port A index.
- rt_addr  in  ADDR_W  read port B index.
- rs_data  out  DATA_W  read port A data, combinational.
- rt_data  out  DATA_W  read port B data, combinational.
- reserve_valid  in  1  an instruction with a register destination issues this cycle.
- reserve_addr  in  ADDR_W  destination index selected by the destination mux.
- wb_valid  in  1  write-back this cycle.
- wb_addr  in  ADDR_W  write-back index.
- wb_data  in  DATA_W  write-back value.
- stall  out  1  a source register has an unresolved pending write; combinational.
- err_overflow  out  1  sticky: reserve hit a saturated counter.
- err_underflow  out  1  sticky: write-back to a register with counter 0.

Behaviour:
- Register 0:
  - Reads always return 0.
  - Writes to 0 are ignored.
  - Reservations of 0 are ignored and never flag errors.
  - Its counter is constant 0.
- Write: at the rising edge with wb_valid=1 and wb_addr!=0, regs[wb_addr] <= wb_data.
- Read: rs_data =
  - 0 if rs_addr==0;
  - else wb_data if wb_valid and wb_addr==rs_addr (same-cycle bypass);
  - else regs[rs_addr].
  - rt_data is identical, using rt_addr.
- Scoreboard: pend[i] is CNT_W bits. Each edge computes pend_next[i] = pend[i] + inc - dec, where:
  - inc = reserve_valid && reserve_addr==i && i!=0;
  - dec = wb_valid && wb_addr==i && i!=0.
  - Simultaneous inc and dec on the same index leaves pend unchanged and raises no error.
- Saturation:
  - inc with pend==max and no dec: pend stays max, err_overflow <= 1.
  - dec with pend==0 and no inc: pend stays 0, err_underflow <= 1; the data write still happens.
  - inc and dec together on the same index never flag an error, including at pend==0 or max.
- Stall: stall = hz(rs_addr) | hz(rt_addr), where hz(a) = a!=0 && pend[a]!=0 && !(wb_valid && wb_addr==a && pend[a]==1).
  - The last outstanding write completing this cycle is satisfied by the bypass.
  - Stall does not consider the same-cycle reserve_* inputs.
- Error flags are sticky until reset.
- Reset (reset_n=0 at an edge):
  - all pend <= 0;
  - err_overflow <= 0, err_underflow <= 0;
  - regs per the optional feature.
  - During reset, reserve and write-back are ignored.
  - Reset mid-operation discards all pending reservations.
  - Post-reset outputs: stall=0, errors=0, reads per the register contents.
- Latency: write visible through the array one cycle after the write edge, and in the same cycle via the bypass.

Optional Feature:
- REGBANK_RESET_CLEAR_EN defined: synchronous reset also clears regs[1..31] to 0.
- Not defined: register contents are not reset and hold their prior values (X after power-up in simulation).
- Scoreboard and error flags reset in both cases.

Decomposition:
- Shared package mips_regbank_pkg: DATA_W, ADDR_W, CNT_W, REG_ZERO=0, NUM_REGS=32, and the reg_addr_t/reg_data_t typedefs.
- One sub-module, regbank_scoreboard: the pend counter array, saturation/error logic and stall computation.
- The top module holds the data array and bypass muxes.

Test Plan:
- Reset with reset_n=0 for 2 cycles (feature enabled) -> all reads 0, stall=0, err_overflow=0, err_underflow=0.
- wb_valid=1, wb_addr=8, wb_data=0xDEADBEEF with rs_addr=8 in the same cycle -> rs_data=0xDEADBEEF via bypass. Next cycle, wb_valid=0 -> rs_data=0xDEADBEEF from the array.
- wb to addr 0 with 0x12345678, then rs_addr=rt_addr=0 -> both read 0. Reserve addr 0 -> no stall, no error.
- Reserve addr 5, then rs_addr=5 -> stall=1. Write-back addr 5 with 0xAA and rs_addr=5 -> stall=0, rs_data=0xAA. Next cycle, pend[5]=0.
- Reserve addr 9 twice -> pend[9]=2. One write-back to 9 -> stall stays 1 while reading 9 that cycle. Second write-back -> stall=0.
- Overflow and underflow:
  - Reserve addr 3 four times -> err_overflow=1 on the 4th edge, pend[3]=3.
  - Write-back addr 4 with pend[4]=0 -> err_underflow=1 and regs[4] written.
  - Both flags remain 1 until reset.
